div32_seq: RTL and testbench
============================

# div32_seq

Multi-cycle 32-bit integer divider that sits beside alu32 in the datapath. It performs the inverse of the multiply path: one restoring shift/subtract step per cycle on a 33-bit partial remainder. It accepts one operation at a time through a start/busy/done handshake and holds its results until the next accepted start. Both signed and unsigned division are supported, with flags for divide-by-zero and signed overflow.

## Interface
- WIDTH, 32, operand and result width; all counts below are given for 32.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; forces IDLE and clears all outputs.
- start  in  1  request; sampled only when busy=0.
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned divide; sampled with start.
- dividend  in  32  numerator; sampled with start.
- divisor  in  32  denominator; sampled with start.
- quotient  out  32  registered result.
- remainder  out  32  registered result.
- busy  out  1  high while state=RUN.
- done  out  1  one-cycle pulse when results become valid.
- div_by_zero  out  1  registered flag, valid with done.
- overflow  out  1  registered flag, valid with done.

## Operation
- States:
  - IDLE, RUN, DONE.
  - Reset enters IDLE.
- IDLE or DONE with start=1:
  - Latch the operands.
  - If signed_op=1, latch the magnitudes and record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear the 6-bit step counter.
  - Special cases bypass RUN and go to DONE on the next edge:
    - divisor==0 → quotient=32'hFFFFFFFF, remainder=dividend (raw input), div_by_zero=1, overflow=0.
    - signed_op=1, dividend=32'h80000000, divisor=32'hFFFFFFFF → quotient=32'h80000000, remainder=0, overflow=1, div_by_zero=0.
  - Otherwise the next state is RUN.
- IDLE/DONE with start=0:
  - DONE returns to IDLE.
  - IDLE holds.
  - Outputs are unchanged.
- RUN, one step per cycle:
  - Shift {rem,quo} left one bit; the MSB of the dividend shifts into rem.
  - Compute trial = rem − divisor, 33 bits wide.
  - If trial is non-negative, rem=trial and the quotient LSB is 1; otherwise the quotient LSB is 0.
  - The counter increments each step.
  - After step 32 (counter==31 at the edge), the next state is DONE.
- Entering DONE from RUN:
  - Apply the sign fix-up: quotient = neg_q ? −quo : quo; remainder = neg_r ? −rem : rem.
  - Clear both flags.
- Remainder sign always follows the dividend (truncating division, C semantics).
- start while busy=1 is ignored; there is no queueing.
- Operand inputs may change freely after the sampling edge.
- quotient, remainder and the flags change only on the edge entering DONE, or on reset.

## Timing
- Reset value of every output is 0: quotient, remainder, busy, done, div_by_zero, overflow.
- Normal operation, with start sampled at edge T:
  - busy=1 from T+1 through T+32 (32 cycles).
  - Results update and done=1 during the cycle following edge T+32.
  - Latency: 33 cycles from start edge to done.
- Special cases (divisor==0 or signed overflow):
  - done=1 in the cycle after edge T (latency 1).
  - busy stays 0.
- Back-to-back operation:
  - start=1 during the done cycle is accepted.
  - busy rises on the next edge.
  - done is not extended.
  - Throughput is one divide per 33 cycles.
- done is never high for two consecutive cycles unless two special-case operations are issued back to back.
- Reset asserted mid-RUN:
  - Immediate (asynchronous) return to IDLE with all outputs 0.
  - The in-flight operation is discarded.
  - After deassertion, the first accepted start behaves normally.

## Test plan
- Unsigned 100/7 → done exactly 33 cycles after start, quotient=14, remainder=2, flags=0, busy high for exactly 32 cycles.
- Signed −7/2 (32'hFFFFFFF9, 2) → quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF; also 7/−2 → quotient=32'hFFFFFFFD, remainder=1.
- Divisor 0 with dividend 32'h12345678 → done 1 cycle later, quotient=32'hFFFFFFFF, remainder=32'h12345678, div_by_zero=1.
- Signed 32'h80000000 / 32'hFFFFFFFF → done 1 cycle later, overflow=1, quotient=32'h80000000, remainder=0.
- Unsigned 32'hFFFFFFFF/1 issued, then a second start (10/3) driven during the done cycle while the first's start is re-pulsed mid-RUN → mid-RUN start ignored; results FFFFFFFF/0, then 3/1 exactly 33 cycles later.
- reset driven low at step 15 of 1000/3 → all outputs 0 immediately; after release, 9/4 → quotient=2, remainder=1.

Source files
------------

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider, signed/unsigned, with div-by-zero and overflow flags
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic             overflow_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH:0]   rem_sh, trial;
    logic             a_neg, b_neg;
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    assign a_neg  = signed_op_i & dividend_i[WIDTH-1];
    assign b_neg  = signed_op_i & divisor_i[WIDTH-1];
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign busy_o        = state_q == RUN;
    assign done_o        = state_q == DONE;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;
    // Next-state and datapath: operand capture, one shift/subtract step per RUN cycle, result fix-up
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        case (state_q)
            RUN: begin
                rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WIDTH - 1)) begin
                    state_d     = DONE;
                    quotient_d  = neg_q_q ? -quo_d : quo_d;
                    remainder_d = neg_r_q ? -rem_d : rem_d;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (start_i) begin
                    rem_d   = '0;
                    quo_d   = a_neg ? -dividend_i : dividend_i;
                    dvs_d   = b_neg ? -divisor_i : divisor_i;
                    neg_q_d = a_neg ^ b_neg;
                    neg_r_d = a_neg;
                    cnt_d   = '0;
                    state_d = RUN;
                    if (divisor_i == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                    end else if (a_neg && dividend_i[WIDTH-2:0] == '0 && divisor_i == '1) begin
                        state_d     = DONE;
                        quotient_d  = dividend_i;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                    end
                end
            end
        endcase
    end
    // State and datapath registers, cleared asynchronously on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed-vector self-checking bench for div32_seq
module tb_div32_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic [31:0] quotient, remainder;
    logic        busy, done, div_by_zero, overflow;
    int          checks = 0, failures = 0;
    int          lat, bc;

    div32_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_op_i(signed_op),
        .dividend_i(dividend), .divisor_i(divisor), .quotient_o(quotient),
        .remainder_o(remainder), .busy_o(busy), .done_o(done),
        .div_by_zero_o(div_by_zero), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; signed_op = sg; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0; signed_op = 1'($urandom); dividend = $urandom; divisor = $urandom;
    endtask

    task automatic wait_done(output int l, output int n);
        l = 1; n = 0;
        while (l < 100) begin
            @(negedge clk);
            if (done) break;
            n += int'(busy);
            @(posedge clk);
            l++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q"}, quotient, 0);
        chk({tag, "_r"}, remainder, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dz"}, div_by_zero, 0);
        chk({tag, "_ov"}, overflow, 0);
    endtask

    task automatic run(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov,
                       input int el, input int eb);
        @(negedge clk);
        issue(sg, a, b);
        wait_done(lat, bc);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_busycyc"}, bc, eb);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dz"}, div_by_zero, dz);
        chk({tag, "_ov"}, overflow, ov);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("u100_7",  0, 100,          7,            14,           2,            0, 0, 33, 32);
        run("s-7_2",   1, 32'hFFFFFFF9, 2,            32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 33, 32);
        run("s7_-2",   1, 7,            32'hFFFFFFFE, 32'hFFFFFFFD, 1,            0, 0, 33, 32);
        run("s-100_-7",1, 32'hFFFFFF9C, 32'hFFFFFFF9, 14,           32'hFFFFFFFE, 0, 0, 33, 32);
        run("u_big",   0, 32'h80000000, 32'hFFFFFFFF, 0,            32'h80000000, 0, 0, 33, 32);
        run("dz",      0, 32'h12345678, 0,            32'hFFFFFFFF, 32'h12345678, 1, 0, 1, 0);
        run("ovf",     1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,            0, 1, 1, 0);
        // back-to-back with an ignored start mid-RUN
        @(negedge clk);
        issue(0, 32'hFFFFFFFF, 1);
        repeat (10) @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 10; divisor = 3;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("b2b1_q", quotient, 32'hFFFFFFFF);
        chk("b2b1_r", remainder, 0);
        issue(0, 10, 3);
        chk("b2b_done_not_ext", done, 0);
        chk("b2b_busy_rise", busy, 1);
        wait_done(lat, bc);
        chk("b2b2_lat", lat, 33);
        chk("b2b2_busycyc", bc, 32);
        chk("b2b2_q", quotient, 3);
        chk("b2b2_r", remainder, 1);
        // asynchronous reset mid-RUN
        @(negedge clk);
        issue(0, 1000, 3);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 0, 9, 4, 2, 1, 0, 0, 33, 32);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
